keypad_entry: RTL and testbench

Scans a 4x4 matrix keypad, debounces presses, and builds the 4-digit BCD entry word and last-key code consumed by the dynamic 7-segment display driver (`num[15:0]`, `key[3:0]`). It sits directly upstream of the display stage and alongside the access-control logic. That logic reads the `enter` strobe and the `num` value.

---
 rtl/keypad_entry_if.sv | 20 ++
 rtl/keypad_entry.sv | 189 ++++++++++++++++++
 tb/tb_keypad_entry.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// Keypad / display bundle: the scanner drives the rows and the entry outputs,
// the keypad matrix and downstream consumers sit on the slave side.
interface keypad_entry_if;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] num;
    logic [3:0]  key;
    logic        key_valid;
    logic        enter;

    modport master (
        input  col,
        output row, num, key, key_valid, enter
    );

    modport slave (
        output col,
        input  row, num, key, key_valid, enter
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with press/release debounce, building a 4-digit
// BCD entry word and reporting the last accepted key code.
module keypad_entry #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_entry_if.master bus
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_TICKS);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HOLD
    } state_t;

    // Key code for a (row, column) position of the matrix.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-index active (low) column; only meaningful when some bit is low.
    function automatic logic [1:0] low_col(input logic [3:0] c);
        logic [1:0] idx;
        if (!c[0])      idx = 2'd0;
        else if (!c[1]) idx = 2'd1;
        else if (!c[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    logic [3:0]       col_s1_q, col_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       colx_q, colx_d;
    logic [DEB_W-1:0] deb_q, deb_d, deb_inc;
    logic [15:0]      num_q, num_d;
    logic [3:0]       key_q, key_d;
    logic             kv_q, kv_d;
    logic             enter_q, enter_d;
    logic             accept;
    logic [3:0]       code;

    // Two-flop synchronizer for the asynchronous column inputs (idle = high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
        end else begin
            col_s1_q <= bus.col;
            col_s2_q <= col_s1_q;
        end
    end

    assign tick  = (div_q == DIV_MAX);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    // State, scan position, debounce count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            state_q <= S_SCAN;
            row_q   <= 2'd0;
            colx_q  <= 2'd0;
            deb_q   <= '0;
            num_q   <= 16'h0000;
            key_q   <= 4'h0;
            kv_q    <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            row_q   <= row_d;
            colx_q  <= colx_d;
            deb_q   <= deb_d;
            num_q   <= num_d;
            key_q   <= key_d;
            kv_q    <= kv_d;
            enter_q <= enter_d;
        end
    end

    // Next-state logic: scan, debounce the press, then wait for a clean release.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        colx_d  = colx_q;
        deb_d   = deb_q;
        accept  = 1'b0;
        deb_inc = deb_q + DEB_W'(1);
        case (state_q)
            S_SCAN: begin
                if (tick) begin
                    if (col_s2_q != 4'hF) begin
                        colx_d  = low_col(col_s2_q);
                        deb_d   = '0;
                        state_d = S_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (tick) begin
                    if (!col_s2_q[colx_q]) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            accept  = 1'b1;
                            deb_d   = '0;
                            state_d = S_HOLD;
                        end
                    end else begin
                        // Bounce: give up without output and move on.
                        state_d = S_SCAN;
                        row_d   = row_q + 2'd1;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    if (col_s2_q == 4'hF) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            deb_d   = '0;
                            state_d = S_SCAN;
                            row_d   = row_q + 2'd1;
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    // Accept handling: update key/num and emit one-cycle strobes.
    always_comb begin
        code    = key_code(row_q, colx_q);
        num_d   = num_q;
        key_d   = key_q;
        kv_d    = accept;
        enter_d = 1'b0;
        if (accept) begin
            key_d = code;
            if (code <= 4'h9) begin
                num_d = {num_q[11:0], code};
            end else if (code == 4'hE) begin
                num_d = 16'h0000;
            end else if (code == 4'hF) begin
                enter_d = 1'b1;
            end
        end
    end

    assign bus.row       = ~(4'b0001 << row_q);
    assign bus.num       = num_q;
    assign bus.key       = key_q;
    assign bus.key_valid = kv_q;
    assign bus.enter     = enter_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a small keypad matrix model.
module tb_keypad_entry;
    localparam int SCAN_DIV  = 4;
    localparam int DEB_TICKS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_if bus();

    keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [15:0] pressed;
    logic        ovr_en;
    logic [3:0]  ovr_col;
    logic [3:0]  kcol;

    // Matrix model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        kcol = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !bus.row[r]) kcol[c] = 1'b0;
        bus.col = ovr_en ? ovr_col : kcol;
    end

    int checks = 0;
    int failures = 0;
    int kv_cnt = 0;
    int en_bad = 0;

    always @(posedge clk) begin
        if (bus.key_valid) kv_cnt <= kv_cnt + 1;
        if (bus.enter && !bus.key_valid) en_bad <= en_bad + 1;
    end

    typedef struct {
        int          r;
        int          c;
        logic [3:0]  k;
        logic [15:0] n;
        logic        en;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_kv(output logic got, output logic [3:0] k,
                           output logic [15:0] n, output logic en);
        got = 1'b0; k = 4'h0; n = 16'h0; en = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.key_valid) begin
                got = 1'b1; k = bus.key; n = bus.num; en = bus.enter;
            end
        end
    endtask

    task automatic release_all();
        pressed = 16'h0;
        ovr_en  = 1'b0;
        ovr_col = 4'hF;
        repeat (40) @(negedge clk);
    endtask

    task automatic press_check(input string nm, input int r, input int c,
                               input logic [3:0] ek, input logic [15:0] en_num, input logic een);
        logic got, en;
        logic [3:0] k;
        logic [15:0] n;
        int base;
        base = kv_cnt;
        pressed[r*4+c] = 1'b1;
        wait_kv(got, k, n, en);
        chk({nm, "_valid"}, got, 1'b1);
        chk({nm, "_key"}, k, ek);
        chk({nm, "_num"}, n, en_num);
        chk({nm, "_enter"}, en, een);
        release_all();
        chk({nm, "_pulses"}, kv_cnt - base, 1);
    endtask

    initial begin
        logic got, en;
        logic [3:0] k;
        logic [15:0] n;
        int base;

        vecs[0]  = '{0, 0, 4'h1, 16'h0001, 1'b0};
        vecs[1]  = '{0, 1, 4'h2, 16'h0012, 1'b0};
        vecs[2]  = '{0, 2, 4'h3, 16'h0123, 1'b0};
        vecs[3]  = '{1, 0, 4'h4, 16'h1234, 1'b0};
        vecs[4]  = '{1, 1, 4'h5, 16'h2345, 1'b0};
        vecs[5]  = '{3, 0, 4'hE, 16'h0000, 1'b0};
        vecs[6]  = '{0, 0, 4'h1, 16'h0001, 1'b0};
        vecs[7]  = '{0, 1, 4'h2, 16'h0012, 1'b0};
        vecs[8]  = '{0, 2, 4'h3, 16'h0123, 1'b0};
        vecs[9]  = '{1, 0, 4'h4, 16'h1234, 1'b0};
        vecs[10] = '{3, 2, 4'hF, 16'h1234, 1'b1};
        vecs[11] = '{3, 0, 4'hE, 16'h0000, 1'b0};
        vecs[12] = '{0, 3, 4'hA, 16'h0000, 1'b0};
        vecs[13] = '{3, 3, 4'hD, 16'h0000, 1'b0};
        vecs[14] = '{2, 2, 4'h9, 16'h0009, 1'b0};

        pressed = 16'h0;
        ovr_en  = 1'b0;
        ovr_col = 4'hF;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_row", bus.row, 4'b1110);
        chk("rst_num", bus.num, 16'h0000);
        chk("rst_key", bus.key, 4'h0);
        chk("rst_kv", bus.key_valid, 1'b0);
        chk("rst_enter", bus.enter, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Entry and control keys
        for (int i = 0; i < 15; i++)
            press_check($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].k, vecs[i].n, vecs[i].en);

        // Bounce on key 1: low for two ticks only
        base = kv_cnt;
        for (int i = 0; i < 100 && bus.row == 4'b1110; i++) @(negedge clk);
        for (int i = 0; i < 100 && bus.row != 4'b1110; i++) @(negedge clk);
        ovr_col = 4'b1110;
        ovr_en  = 1'b1;
        repeat (8) @(negedge clk);
        chk("bounce_row_held", bus.row, 4'b1110);
        ovr_col = 4'hF;
        repeat (4) @(negedge clk);
        chk("bounce_row_next", bus.row, 4'b1101);
        release_all();
        chk("bounce_no_kv", kv_cnt - base, 0);
        chk("bounce_num", bus.num, 16'h0009);

        // Long hold of 9, then 0 pressed while 9 still held
        base = kv_cnt;
        pressed[2*4+2] = 1'b1;
        wait_kv(got, k, n, en);
        chk("hold9_valid", got, 1'b1);
        chk("hold9_num", n, 16'h0099);
        repeat (400) @(negedge clk);
        chk("hold9_pulses", kv_cnt - base, 1);
        pressed[3*4+1] = 1'b1;
        repeat (100) @(negedge clk);
        chk("hold9_chord_ignored", kv_cnt - base, 1);
        chk("hold9_chord_num", bus.num, 16'h0099);
        release_all();
        press_check("zero_after", 3, 1, 4'h0, 16'h0990, 1'b0);

        // Same-row chord 4 + 6
        base = kv_cnt;
        pressed[1*4+0] = 1'b1;
        pressed[1*4+2] = 1'b1;
        wait_kv(got, k, n, en);
        chk("chord_valid", got, 1'b1);
        chk("chord_key", k, 4'h4);
        chk("chord_num", n, 16'h9904);
        release_all();
        chk("chord_pulses", kv_cnt - base, 1);

        // Release debounce: toggling column keeps HOLD
        base = kv_cnt;
        pressed[2*4+1] = 1'b1;
        wait_kv(got, k, n, en);
        chk("rel_valid", got, 1'b1);
        chk("rel_key", k, 4'h8);
        ovr_col = 4'b1101;
        ovr_en  = 1'b1;
        pressed = 16'h0;
        for (int i = 0; i < 10; i++) begin
            repeat (4) @(negedge clk);
            ovr_col = (i % 2 == 0) ? 4'hF : 4'b1101;
            chk($sformatf("rel_toggle%0d_row", i), bus.row, 4'b1011);
        end
        ovr_col = 4'hF;
        repeat (16) @(negedge clk);
        chk("rel_row_advanced", bus.row != 4'b1011, 1'b1);
        release_all();
        chk("rel_pulses", kv_cnt - base, 1);

        // Reset during HOLD
        pressed[2*4+0] = 1'b1;
        wait_kv(got, k, n, en);
        chk("pre_rst_num", n, 16'h0487);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("hold_rst_row", bus.row, 4'b1110);
        chk("hold_rst_num", bus.num, 16'h0000);
        chk("hold_rst_key", bus.key, 4'h0);
        chk("hold_rst_kv", bus.key_valid, 1'b0);
        pressed = 16'h0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        base = kv_cnt;
        repeat (100) @(negedge clk);
        chk("hold_rst_no_kv", kv_cnt - base, 0);
        chk("hold_rst_num_after", bus.num, 16'h0000);

        chk("enter_without_kv", en_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
